// File: rtl/s10_dot_accum.sv
// Dot-product accumulator: sums signed pair-adder beats per vector and presents
// the result, beat count and overflow flag on a valid/ready output. Optional macro: DOT_ACC_SAT_EN.
module s10_dot_accum #(
  parameter int IN_W  = 14,
  parameter int ACC_W = 32,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [LEN_W-1:0] out_count,
  output logic             out_ovf
);

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [LEN_W-1:0] CNT_MAX = {LEN_W{1'b1}};
  localparam logic [LEN_W-1:0] CNT_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  // Signed add overflow: operands agree in sign but the sum does not.
  function automatic logic add_ovf(input logic [ACC_W-1:0] a,
                                   input logic [ACC_W-1:0] b,
                                   input logic [ACC_W-1:0] s);
    return (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
  endfunction

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;
  logic [LEN_W-1:0] out_count_q, out_count_d;
  logic             out_ovf_q, out_ovf_d;

  logic [ACC_W-1:0] in_ext_s;
  logic [ACC_W-1:0] sum_raw_s;
  logic [ACC_W-1:0] sum_s;
  logic             add_ovf_s;
  logic [LEN_W-1:0] cnt_inc_s;
  logic             beat_s;
  logic             drain_s;

  assign in_ext_s  = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};
  assign sum_raw_s = acc_q + in_ext_s;
  assign add_ovf_s = add_ovf(acc_q, in_ext_s, sum_raw_s);
  assign cnt_inc_s = (cnt_q == CNT_MAX) ? CNT_MAX : (cnt_q + CNT_ONE);

`ifdef DOT_ACC_SAT_EN
  // Clamp toward the operand sign so a saturated accumulator stays pinned.
  assign sum_s = add_ovf_s ? (acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX) : sum_raw_s;
`else
  assign sum_s = sum_raw_s;
`endif

  // Output register frees in the same cycle it is consumed, so no bubble.
  assign in_ready = ~out_valid_q | out_ready;
  assign beat_s   = in_valid & in_ready;
  assign drain_s  = out_valid_q & out_ready;

  // Next-state: accumulate non-last beats, close the vector on the last one.
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    if (beat_s && in_last) begin
      out_data_d  = sum_s;
      out_count_d = cnt_inc_s;
      out_ovf_d   = ovf_q | add_ovf_s;
      out_valid_d = 1'b1;
      acc_d       = {ACC_W{1'b0}};
      cnt_d       = {LEN_W{1'b0}};
      ovf_d       = 1'b0;
    end else if (beat_s) begin
      acc_d       = sum_s;
      cnt_d       = cnt_inc_s;
      ovf_d       = ovf_q | add_ovf_s;
      out_valid_d = drain_s ? 1'b0 : out_valid_q;
    end else if (drain_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers; reset drops any partial vector and pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= {ACC_W{1'b0}};
      cnt_q       <= {LEN_W{1'b0}};
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= {ACC_W{1'b0}};
      out_count_q <= {LEN_W{1'b0}};
      out_ovf_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

endmodule
